prop_sequencer: RTL and testbench

PROP_SEQUENCER -- requirements
Module: prop_sequencer

---
 rtl/prop_sequencer_if.sv | 36 +++
 rtl/prop_sequencer.sv | 136 +++++++++++++
 tb/tb_prop_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prop_sequencer_if.sv
// Handshake and layer-enable bundle between the propagation sequencer and the
// unit-layer array; state_dbg_out exposes the FSM state (IDLE=0 .. DONE=5).
interface prop_sequencer_if #(
   parameter int NUM_LAYERS = 4
);
   // Valid/ready: a sample transfers on a rising edge where sample_valid_in and
   // sample_ready_out are both high and stop_in is low (stop_in wins and leaves
   // WAIT instead). Ready is registered and is high exactly while in WAIT;
   // valid may rise or fall in any cycle without a transfer penalty.
   logic                  start_in;
   logic                  stop_in;
   logic                  sample_valid_in;
   logic                  sample_ready_out;
   logic [NUM_LAYERS-1:0] fd_prop_out;
   logic [NUM_LAYERS-1:0] bk_prop_out;
   logic                  loss_strobe_out;
   logic [3:0]            layer_idx_out;
   logic [7:0]            sample_count_out;
   logic                  batch_done_out;
   logic                  busy_out;
   logic [2:0]            state_dbg_out;

   modport master (
      output start_in, stop_in, sample_valid_in,
      input  sample_ready_out, fd_prop_out, bk_prop_out, loss_strobe_out,
             layer_idx_out, sample_count_out, batch_done_out, busy_out,
             state_dbg_out
   );

   modport slave (
      input  start_in, stop_in, sample_valid_in,
      output sample_ready_out, fd_prop_out, bk_prop_out, loss_strobe_out,
             layer_idx_out, sample_count_out, batch_done_out, busy_out,
             state_dbg_out
   );
endinterface

// File: rtl/prop_sequencer.sv
// Sequences one training sample through the layer array: forward sweep, loss
// latch, backward sweep, then batch bookkeeping. All outputs are registered.
module prop_sequencer #(
   parameter int NUM_LAYERS = 4,
   parameter int BATCH_SIZE = 8
) (
   input logic             clk_in,
   input logic             rst_in,
   prop_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_FWD  = 3'd2,
      S_LOSS = 3'd3,
      S_BWD  = 3'd4,
      S_DONE = 3'd5
   } state_e;

   localparam logic [3:0]            LAST_IDX  = 4'(NUM_LAYERS - 1);
   localparam logic [7:0]            BATCH_LIM = 8'(BATCH_SIZE);
   localparam logic [NUM_LAYERS-1:0] ONE_HOT0  = NUM_LAYERS'(1);

   state_e                state_q, state_d;
   logic [3:0]            idx_q, idx_d;
   logic [7:0]            count_q, count_d;
   logic [7:0]            count_inc;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  loss_q, loss_d;
   logic                  batch_q, batch_d;
   logic [3:0]            lidx_q, lidx_d;
   logic [NUM_LAYERS-1:0] fd_q, fd_d;
   logic [NUM_LAYERS-1:0] bk_q, bk_d;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      count_d   = count_q;
      batch_d   = 1'b0;
      count_inc = count_q + 8'd1;
      case (state_q)
         S_IDLE: if (bus.start_in) state_d = S_WAIT;
         S_WAIT: begin
            if (bus.stop_in) begin
               state_d = S_IDLE;
            end else if (bus.sample_valid_in) begin
               state_d = S_FWD;
               idx_d   = 4'd0;
            end
         end
         S_FWD: begin
            if (idx_q == LAST_IDX) state_d = S_LOSS;
            else                   idx_d   = idx_q + 4'd1;
         end
         S_LOSS: begin
            state_d = S_BWD;
            idx_d   = LAST_IDX;
         end
         S_BWD: begin
            // The count moves on entry to DONE so the DONE cycle shows the new total.
            if (idx_q == 4'd0) begin
               state_d = S_DONE;
               if (count_inc == BATCH_LIM) begin
                  count_d = 8'd0;
                  batch_d = 1'b1;
               end else begin
                  count_d = count_inc;
               end
            end else begin
               idx_d = idx_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = bus.stop_in ? S_IDLE : S_WAIT;
            idx_d   = 4'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the next state so each output lands in a flop.
   always_comb begin
      ready_d = (state_d == S_WAIT);
      busy_d  = (state_d != S_IDLE);
      loss_d  = (state_d == S_LOSS);
      fd_d    = '0;
      bk_d    = '0;
      lidx_d  = 4'd0;
      if (state_d == S_FWD) begin
         fd_d   = ONE_HOT0 << idx_d;
         lidx_d = idx_d;
      end else if (state_d == S_BWD) begin
         bk_d   = ONE_HOT0 << idx_d;
         lidx_d = idx_d;
      end else if (state_d == S_LOSS) begin
         lidx_d = LAST_IDX;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         count_q <= 8'd0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         loss_q  <= 1'b0;
         batch_q <= 1'b0;
         lidx_q  <= 4'd0;
         fd_q    <= '0;
         bk_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         loss_q  <= loss_d;
         batch_q <= batch_d;
         lidx_q  <= lidx_d;
         fd_q    <= fd_d;
         bk_q    <= bk_d;
      end
   end

   assign bus.sample_ready_out = ready_q;
   assign bus.busy_out         = busy_q;
   assign bus.loss_strobe_out  = loss_q;
   assign bus.batch_done_out   = batch_q;
   assign bus.layer_idx_out    = lidx_q;
   assign bus.sample_count_out = count_q;
   assign bus.fd_prop_out      = fd_q;
   assign bus.bk_prop_out      = bk_q;
   assign bus.state_dbg_out    = state_q;
endmodule

// File: tb/tb_prop_sequencer.sv
// Bench for prop_sequencer: directed scenarios plus a randomized run against a
// phase/offset model of the sample schedule.
`timescale 1ns/1ps
module tb_prop_sequencer;
   localparam int NL  = 4;
   localparam int BS  = 3;
   localparam int LAT = 2*NL + 2;
   localparam int VW  = 16 + 2*NL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   prop_sequencer_if #(.NUM_LAYERS(NL)) bus ();

   prop_sequencer #(.NUM_LAYERS(NL), .BATCH_SIZE(BS)) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- clock/reset and driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start_in = 1'b0;
      bus.stop_in = 1'b0;
      bus.sample_valid_in = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // ---------------- reference schedule (offset k after handshake) ----------------
   function automatic logic [NL-1:0] exp_fd(int k);
      logic [NL-1:0] one = NL'(1);
      return (k >= 1 && k <= NL) ? one << (k - 1) : '0;
   endfunction

   function automatic logic [NL-1:0] exp_bk(int k);
      logic [NL-1:0] one = NL'(1);
      return (k >= NL + 2 && k <= 2*NL + 1) ? one << (2*NL + 1 - k) : '0;
   endfunction

   function automatic logic exp_loss(int k);
      return (k == NL + 1);
   endfunction

   function automatic logic [3:0] exp_idx(int k);
      if (k >= 1 && k <= NL)          return 4'(k - 1);
      if (k == NL + 1)                return 4'(NL - 1);
      if (k >= NL + 2 && k <= 2*NL+1) return 4'(2*NL + 1 - k);
      return 4'd0;
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {bus.sample_ready_out, bus.busy_out, bus.loss_strobe_out, bus.batch_done_out,
              bus.layer_idx_out, bus.sample_count_out, bus.fd_prop_out, bus.bk_prop_out};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [VW-1:0] act;
      do_reset();
      act = dut_vec();
      checks++;
      if (act !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=%h", act, {VW{1'b0}});
      end
      checks++;
      if (bus.state_dbg_out !== 3'd0) begin
         failures++;
         $display("FAIL reset_state got=%0d exp=0", bus.state_dbg_out);
      end
      rst = 1'b1;
      bus.start_in = 1'b1;
      cyc();
      checks++;
      if (bus.busy_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_priority busy got=%b exp=0", bus.busy_out);
      end
      bus.start_in = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single_sample();
      logic [NL*2+5:0] act, exp;
      do_reset();
      bus.start_in = 1'b1;
      cyc();
      bus.start_in = 1'b0;
      bus.sample_valid_in = 1'b1;
      checks++;
      if (bus.sample_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL single_wait_ready got=%b exp=1", bus.sample_ready_out);
      end
      for (int k = 1; k <= LAT; k++) begin
         cyc();
         act = {bus.fd_prop_out, bus.bk_prop_out, bus.loss_strobe_out, bus.busy_out, bus.layer_idx_out};
         exp = {exp_fd(k), exp_bk(k), exp_loss(k), 1'b1, exp_idx(k)};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL single_seq k=%0d got=%h exp=%h", k, act, exp);
         end
         if (k >= LAT - 1) begin
            checks++;
            if (bus.sample_count_out !== 8'((k == LAT) ? 1 : 0)) begin
               failures++;
               $display("FAIL single_count k=%0d got=%0d exp=%0d", k, bus.sample_count_out, (k == LAT) ? 1 : 0);
            end
         end
      end
      bus.sample_valid_in = 1'b0;
      cyc();
      checks++;
      if (bus.sample_ready_out !== 1'b1 || bus.busy_out !== 1'b1) begin
         failures++;
         $display("FAIL single_back_to_wait ready=%b busy=%b exp=1,1", bus.sample_ready_out, bus.busy_out);
      end
   endtask

   task automatic test_back_to_back();
      int nbatch = 0;
      do_reset();
      bus.start_in = 1'b1;
      cyc();
      bus.start_in = 1'b0;
      bus.sample_valid_in = 1'b1;
      for (int s = 0; s < 3; s++) begin
         for (int k = 1; k <= LAT + 1; k++) begin
            cyc();
            if (bus.batch_done_out === 1'b1) nbatch++;
            if (k == LAT) begin
               checks++;
               if (bus.sample_count_out !== 8'((s + 1) % BS) || bus.batch_done_out !== (s == 2)) begin
                  failures++;
                  $display("FAIL b2b_done s=%0d count=%0d batch=%b exp=%0d,%b",
                           s, bus.sample_count_out, bus.batch_done_out, (s + 1) % BS, (s == 2));
               end
            end
         end
      end
      bus.sample_valid_in = 1'b0;
      checks++;
      if (nbatch != 1) begin
         failures++;
         $display("FAIL b2b_batch_pulses got=%0d exp=1", nbatch);
      end
   endtask

   task automatic test_stop_mid();
      do_reset();
      bus.start_in = 1'b1;
      cyc();
      bus.start_in = 1'b0;
      bus.sample_valid_in = 1'b1;
      for (int k = 1; k <= LAT + 1; k++) cyc();
      for (int k = 1; k <= LAT; k++) begin
         cyc();
         if (k == 2) bus.stop_in = 1'b1;
      end
      checks++;
      if (bus.sample_count_out !== 8'd2 || bus.busy_out !== 1'b1) begin
         failures++;
         $display("FAIL stop_done count=%0d busy=%b exp=2,1", bus.sample_count_out, bus.busy_out);
      end
      cyc();
      checks++;
      if (bus.busy_out !== 1'b0 || bus.sample_ready_out !== 1'b0 || bus.sample_count_out !== 8'd2) begin
         failures++;
         $display("FAIL stop_idle busy=%b ready=%b count=%0d exp=0,0,2",
                  bus.busy_out, bus.sample_ready_out, bus.sample_count_out);
      end
      bus.stop_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (bus.busy_out !== 1'b0 || bus.fd_prop_out !== '0) begin
            failures++;
            $display("FAIL stop_idle_ignores_valid busy=%b fd=%b exp=0,0", bus.busy_out, bus.fd_prop_out);
         end
      end
      bus.sample_valid_in = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [VW-1:0] act;
      do_reset();
      bus.start_in = 1'b1;
      cyc();
      bus.start_in = 1'b0;
      bus.sample_valid_in = 1'b1;
      for (int k = 1; k <= NL + 3; k++) cyc();
      checks++;
      if (bus.bk_prop_out !== 4'b0100 || bus.layer_idx_out !== 4'd2) begin
         failures++;
         $display("FAIL rstmid_bwd2 bk=%b idx=%0d exp=0100,2", bus.bk_prop_out, bus.layer_idx_out);
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      act = dut_vec();
      checks++;
      if (act !== '0 || bus.state_dbg_out !== 3'd0) begin
         failures++;
         $display("FAIL rstmid_clear got=%h state=%0d exp=0,0", act, bus.state_dbg_out);
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         act = dut_vec();
         checks++;
         if (act !== '0) begin
            failures++;
            $display("FAIL rstmid_quiet got=%h exp=0", act);
         end
      end
      bus.start_in = 1'b1;
      cyc();
      bus.start_in = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         cyc();
         if (k == 1) begin
            checks++;
            if (bus.fd_prop_out !== exp_fd(1)) begin
               failures++;
               $display("FAIL rstmid_resume_fd got=%b exp=%b", bus.fd_prop_out, exp_fd(1));
            end
         end
      end
      checks++;
      if (bus.sample_count_out !== 8'd1) begin
         failures++;
         $display("FAIL rstmid_resume_count got=%0d exp=1", bus.sample_count_out);
      end
      bus.sample_valid_in = 1'b0;
   endtask

   task automatic test_wait_gap();
      logic [NL*2:0] act, exp;
      do_reset();
      bus.start_in = 1'b1;
      cyc();
      bus.start_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.sample_ready_out !== 1'b1 || bus.fd_prop_out !== '0 || bus.bk_prop_out !== '0) begin
            failures++;
            $display("FAIL gap_wait i=%0d ready=%b fd=%b bk=%b exp=1,0,0",
                     i, bus.sample_ready_out, bus.fd_prop_out, bus.bk_prop_out);
         end
         cyc();
      end
      bus.sample_valid_in = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         cyc();
         bus.sample_valid_in = 1'b0;
         bus.start_in = (k == 1);
         act = {bus.fd_prop_out, bus.bk_prop_out, bus.loss_strobe_out};
         exp = {exp_fd(k), exp_bk(k), exp_loss(k)};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL gap_seq k=%0d got=%h exp=%h", k, act, exp);
         end
      end
      bus.start_in = 1'b0;
      cyc();
      checks++;
      if (bus.sample_ready_out !== 1'b1 || bus.sample_count_out !== 8'd1) begin
         failures++;
         $display("FAIL gap_after ready=%b count=%0d exp=1,1", bus.sample_ready_out, bus.sample_count_out);
      end
   endtask

   // Phase/offset model: 0 idle, 1 waiting, 2 inside a sample at offset t.
   task automatic test_random_samples();
      int phase = 0;
      int t = 0;
      int mcount = 0;
      bit mbatch = 1'b0;
      int done_samples = 0;
      int cycles = 0;
      int dut_hs = -1;
      logic [7:0] prev_cnt;
      logic st, sp, vl;
      logic [VW-1:0] act, exp;
      do_reset();
      prev_cnt = bus.sample_count_out;
      while (done_samples < 1000 && cycles < 60000) begin
         exp = {phase == 1, phase != 0,
                phase == 2 && exp_loss(t), mbatch,
                (phase == 2) ? exp_idx(t) : 4'd0, 8'(mcount),
                (phase == 2) ? exp_fd(t) : {NL{1'b0}},
                (phase == 2) ? exp_bk(t) : {NL{1'b0}}};
         act = dut_vec();
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL rand_outputs cyc=%0d got=%h exp=%h", cycles, act, exp);
         end
         checks++;
         if (!$onehot0(bus.fd_prop_out) || !$onehot0(bus.bk_prop_out) ||
             (bus.fd_prop_out != '0 && bus.bk_prop_out != '0)) begin
            failures++;
            $display("FAIL rand_onehot cyc=%0d fd=%b bk=%b", cycles, bus.fd_prop_out, bus.bk_prop_out);
         end
         if (bus.sample_count_out !== prev_cnt && dut_hs >= 0) begin
            checks++;
            if (cycles - dut_hs != LAT) begin
               failures++;
               $display("FAIL rand_latency got=%0d exp=%0d", cycles - dut_hs, LAT);
            end
            dut_hs = -1;
         end
         prev_cnt = bus.sample_count_out;

         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 15) == 0);
         vl = ($urandom_range(0, 2) != 0);
         bus.start_in = st;
         bus.stop_in = sp;
         bus.sample_valid_in = vl;
         if (bus.sample_ready_out && vl && !sp) dut_hs = cycles;

         mbatch = 1'b0;
         case (phase)
            0: if (st) phase = 1;
            1: begin
               if (sp) phase = 0;
               else if (vl) begin
                  phase = 2;
                  t = 1;
               end
            end
            default: begin
               if (t == LAT) begin
                  phase = sp ? 0 : 1;
                  done_samples++;
               end else begin
                  t++;
                  if (t == LAT) begin
                     mcount++;
                     if (mcount == BS) begin
                        mcount = 0;
                        mbatch = 1'b1;
                     end
                  end
               end
            end
         endcase
         cyc();
         cycles++;
      end
      checks++;
      if (done_samples < 1000) begin
         failures++;
         $display("FAIL rand_budget samples=%0d exp=1000", done_samples);
      end
      bus.start_in = 1'b0;
      bus.stop_in = 1'b0;
      bus.sample_valid_in = 1'b0;
   endtask

   initial begin
      bus.start_in = 1'b0;
      bus.stop_in = 1'b0;
      bus.sample_valid_in = 1'b0;
      test_reset();
      test_single_sample();
      test_back_to_back();
      test_stop_mid();
      test_reset_mid();
      test_wait_gap();
      test_random_samples();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
